// File: rtl/fetch_predict_unit_if.sv
// rtl/fetch_predict_unit_if.sv - fetch/resolve/redirect bundle for fetch_predict_unit
//
// Groups every non-clock signal of the fetch predictor.
//   slave  : the predictor itself (takes fetch control and EX resolution,
//            returns fetch PC, prediction, redirect and perf counters)
//   master : the pipeline side driving it
interface fetch_predict_unit_if #(
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             stall;
   logic             halt;
   logic [31:0]      imemaddr;
   logic [31:0]      fetch_npc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             res_valid;
   logic [31:0]      res_pc;
   logic             res_taken;
   logic [31:0]      res_target;
   logic             res_pred_taken;
   logic [31:0]      res_pred_target;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   modport slave (
      input  ihit, stall, halt,
      input  res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      output imemaddr, fetch_npc, pred_taken, pred_target,
      output redirect, redirect_pc, branch_count, mispredict_count
   );

   modport master (
      output ihit, stall, halt,
      output res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      input  imemaddr, fetch_npc, pred_taken, pred_target,
      input  redirect, redirect_pc, branch_count, mispredict_count
   );
endinterface

// File: rtl/fetch_predict_unit.sv
// rtl/fetch_predict_unit.sv - fetch PC, direct-mapped BTB predictor, mispredict redirect
//
// Ports:
//   CLK  - rising-edge clock
//   RST  - asynchronous active-high reset
//   fpu  - fetch_predict_unit_if.slave: fetch control (ihit/stall/halt),
//          fetch PC and prediction, EX resolution, redirect, perf counters
module fetch_predict_unit #(
   parameter logic [31:0] PC_INIT     = 32'h0,
   parameter int          BTB_ENTRIES = 16,
   parameter int          CTR_W       = 2,
   parameter int          CNT_W       = 32
) (
   input logic               CLK,
   input logic               RST,
   fetch_predict_unit_if.slave fpu
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   // Weakly-taken is the MSB alone; weakly-not-taken is one below it (0 when CTR_W=1).
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0]            pc;
   logic [31:0]            pcPlus4;
   logic [BTB_ENTRIES-1:0] btbValid;
   logic [TAG_W-1:0]       btbTag    [BTB_ENTRIES];
   logic [31:0]            btbTarget [BTB_ENTRIES];
   logic [CTR_W-1:0]       btbCtr    [BTB_ENTRIES];
   logic [CNT_W-1:0]       branchCount;
   logic [CNT_W-1:0]       mispredictCount;

   logic [IDX_W-1:0] fIdx;
   logic [TAG_W-1:0] fTag;
   logic             fHit;
   logic             predTaken;
   logic [31:0]      predTarget;

   logic [IDX_W-1:0] rIdx;
   logic [TAG_W-1:0] rTag;
   logic             rHit;
   logic [31:0]      correctPc;
   logic             mispredict;

   // Fetch-side lookup: purely combinational from the current pc.
   assign pcPlus4    = pc + 32'd4;
   assign fIdx       = pc[IDX_W+1:2];
   assign fTag       = pc[31:IDX_W+2];
   assign fHit       = btbValid[fIdx] && (btbTag[fIdx] == fTag);
   assign predTaken  = fHit && btbCtr[fIdx][CTR_W-1];
   assign predTarget = predTaken ? btbTarget[fIdx] : pcPlus4;

   // Resolution side: compare the actual next PC with what was predicted downstream.
   assign rIdx       = fpu.res_pc[IDX_W+1:2];
   assign rTag       = fpu.res_pc[31:IDX_W+2];
   assign rHit       = btbValid[rIdx] && (btbTag[rIdx] == rTag);
   assign correctPc  = fpu.res_taken ? fpu.res_target : fpu.res_pc + 32'd4;
   assign mispredict = fpu.res_valid &&
                       ((fpu.res_taken != fpu.res_pred_taken) || (correctPc != fpu.res_pred_target));

   assign fpu.imemaddr         = pc;
   assign fpu.fetch_npc        = pcPlus4;
   assign fpu.pred_taken       = predTaken;
   assign fpu.pred_target      = predTarget;
   assign fpu.redirect         = mispredict;
   assign fpu.redirect_pc      = fpu.res_valid ? correctPc : 32'd0;
   assign fpu.branch_count     = branchCount;
   assign fpu.mispredict_count = mispredictCount;

   // Halt outranks a redirect; a redirect outranks stall/ihit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc <= PC_INIT;
      end else if (fpu.halt) begin
         pc <= pc;
      end else if (mispredict) begin
         pc <= correctPc;
      end else if (fpu.ihit && !fpu.stall) begin
         pc <= predTarget;
      end
   end

   // Training runs on every resolve, even while the pipe is halted or stalled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btbValid[i]  <= 1'b0;
            btbTag[i]    <= '0;
            btbTarget[i] <= '0;
            btbCtr[i]    <= CTR_WNT;
         end
      end else if (fpu.res_valid) begin
         if (rHit) begin
            if (fpu.res_taken) begin
               btbTarget[rIdx] <= fpu.res_target;
               if (btbCtr[rIdx] != CTR_MAX) btbCtr[rIdx] <= btbCtr[rIdx] + CTR_W'(1);
            end else if (btbCtr[rIdx] != '0) begin
               btbCtr[rIdx] <= btbCtr[rIdx] - CTR_W'(1);
            end
         end else if (fpu.res_taken) begin
            // Miss on a taken branch evicts whatever alias occupied the slot.
            btbValid[rIdx]  <= 1'b1;
            btbTag[rIdx]    <= rTag;
            btbTarget[rIdx] <= fpu.res_target;
            btbCtr[rIdx]    <= CTR_WT;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (fpu.res_valid && branchCount != CNT_MAX) branchCount <= branchCount + CNT_W'(1);
         if (mispredict && mispredictCount != CNT_MAX) mispredictCount <= mispredictCount + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_fetch_predict_unit.sv
// tb/tb_fetch_predict_unit.sv - scoreboard bench for fetch_predict_unit
module tb_fetch_predict_unit;
   localparam int N       = 16;
   localparam int CTR_W   = 2;
   localparam int CNT_W   = 6;
   localparam int CTR_TOP = (1 << CTR_W) - 1;
   localparam int CTR_WT  = 1 << (CTR_W - 1);
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic RST;

   fetch_predict_unit_if #(.CNT_W(CNT_W)) bus ();

   fetch_predict_unit #(
      .PC_INIT(32'h0), .BTB_ENTRIES(N), .CTR_W(CTR_W), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RST(RST), .fpu(bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: BTB slot chosen by word address mod N, owner identified by pc/(4N).
   bit          mValid [N];
   int unsigned mOwner [N];
   logic [31:0] mTgt   [N];
   int          mCtr   [N];
   logic [31:0] mPc;
   int          mBr, mMis;

   typedef struct {
      logic [31:0] pc;
      bit          predTaken;
      logic [31:0] predTarget;
      bit          redirect;
      logic [31:0] redirectPc;
      int          br;
      int          mis;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void mReset();
      for (int i = 0; i < N; i++) begin
         mValid[i] = 0; mOwner[i] = 0; mTgt[i] = 0; mCtr[i] = CTR_WT - 1;
      end
      mPc = 0; mBr = 0; mMis = 0;
   endfunction

   function automatic void mPredict(input logic [31:0] p, output bit t, output logic [31:0] tg);
      int unsigned i;
      bit hit;
      i   = (p / 4) % N;
      hit = mValid[i] && (mOwner[i] == p / (4 * N));
      t   = hit && (mCtr[i] >= CTR_WT);
      tg  = t ? mTgt[i] : p + 4;
   endfunction

   function automatic void mTrain(input logic [31:0] p, input bit t, input logic [31:0] tg);
      int unsigned i;
      bit hit;
      i   = (p / 4) % N;
      hit = mValid[i] && (mOwner[i] == p / (4 * N));
      if (hit && t) begin
         mTgt[i] = tg;
         mCtr[i] = (mCtr[i] < CTR_TOP) ? mCtr[i] + 1 : CTR_TOP;
      end else if (hit) begin
         mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
      end else if (t) begin
         mValid[i] = 1; mOwner[i] = p / (4 * N); mTgt[i] = tg; mCtr[i] = CTR_WT;
      end
   endfunction

   // One clock cycle: drive, queue expected outputs, advance the model across the edge.
   task automatic step(input bit ih, input bit st, input bit hl, input bit rv,
                       input logic [31:0] rpc, input bit rt, input logic [31:0] rtg,
                       input bit rpt, input logic [31:0] rptg);
      exp_t        e;
      bit          pt, mis;
      logic [31:0] ptg, corr;
      bus.ihit = ih; bus.stall = st; bus.halt = hl;
      bus.res_valid = rv; bus.res_pc = rpc; bus.res_taken = rt; bus.res_target = rtg;
      bus.res_pred_taken = rpt; bus.res_pred_target = rptg;
      mPredict(mPc, pt, ptg);
      corr = rt ? rtg : rpc + 4;
      mis  = rv && ((rt != rpt) || (corr != rptg));
      e.pc = mPc; e.predTaken = pt; e.predTarget = ptg;
      e.redirect = mis; e.redirectPc = rv ? corr : 32'd0;
      e.br = mBr; e.mis = mMis;
      sbq.push_back(e);
      @(posedge CLK);
      if (!hl) begin
         if (mis) mPc = corr;
         else if (ih && !st) mPc = ptg;
      end
      if (rv) mTrain(rpc, rt, rtg);
      if (rv && mBr < CNT_TOP) mBr++;
      if (mis && mMis < CNT_TOP) mMis++;
      #1;
   endtask

   task automatic fetch(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic [31:0] rpc, input bit rt, input logic [31:0] rtg,
                          input bit rpt, input logic [31:0] rptg);
      step(0, 0, 0, 1, rpc, rt, rtg, rpt, rptg);
   endtask

   // Force pc to a chosen address through a guaranteed mispredict on 0x1C.
   task automatic gotoPc(input logic [31:0] a);
      resolve(32'h1C, 1, a, 0, 32'h20);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("imemaddr", bus.imemaddr, e.pc);
         check("fetch_npc", bus.fetch_npc, e.pc + 32'd4);
         check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.predTaken});
         check("pred_target", bus.pred_target, e.predTarget);
         check("redirect", {31'd0, bus.redirect}, {31'd0, e.redirect});
         check("redirect_pc", bus.redirect_pc, e.redirectPc);
         check("branch_count", 32'(bus.branch_count), 32'(e.br));
         check("mispredict_count", 32'(bus.mispredict_count), 32'(e.mis));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] holdPc, rpc, rtg, rptg;
      bit          rt, rpt;
      int          misBefore;
      logic [31:0] pcs [8];
      pcs = '{32'h40, 32'h80, 32'h1C, 32'h90, 32'hC0, 32'h44, 32'h100, 32'h200};

      bus.ihit = 0; bus.stall = 0; bus.halt = 0; bus.res_valid = 0; bus.res_pc = 0;
      bus.res_taken = 0; bus.res_target = 0; bus.res_pred_taken = 0; bus.res_pred_target = 0;
      RST = 1'b1;
      mReset();
      repeat (2) @(posedge CLK);
      #1;
      check("reset_pc", bus.imemaddr, 32'h0);
      check("reset_pred", {31'd0, bus.pred_taken}, 32'd0);
      check("reset_brcnt", 32'(bus.branch_count), 32'd0);
      check("reset_miscnt", 32'(bus.mispredict_count), 32'd0);
      RST = 1'b0;

      fetch(4);
      check("seq_pc_10", bus.imemaddr, 32'h10);
      fetch(4);
      check("seq_pc_20", bus.imemaddr, 32'h20);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("hold_pc_20", bus.imemaddr, 32'h20);
      fetch(1);
      check("resume_pc_24", bus.imemaddr, 32'h24);

      resolve(32'h40, 1, 32'h100, 0, 32'h44);
      check("redirect_pc_100", bus.imemaddr, 32'h100);
      check("miscnt_1", 32'(bus.mispredict_count), 32'd1);
      gotoPc(32'h40);
      check("alloc_pred", {31'd0, bus.pred_taken}, 32'd1);
      check("alloc_target", bus.pred_target, 32'h100);

      resolve(32'h40, 0, 32'h0, 1, 32'h100);
      gotoPc(32'h40);
      check("hyst_nt_pred", {31'd0, bus.pred_taken}, 32'd0);
      check("hyst_nt_target", bus.pred_target, 32'h44);
      repeat (3) resolve(32'h40, 1, 32'h100, 1, 32'h100);
      resolve(32'h40, 0, 32'h0, 1, 32'h100);
      gotoPc(32'h40);
      check("hyst_sat_pred", {31'd0, bus.pred_taken}, 32'd1);

      gotoPc(32'h80);
      check("alias_miss", {31'd0, bus.pred_taken}, 32'd0);
      resolve(32'h80, 1, 32'h200, 0, 32'h84);
      gotoPc(32'h40);
      check("alias_evicted", {31'd0, bus.pred_taken}, 32'd0);
      gotoPc(32'h80);
      check("alias_new_pred", {31'd0, bus.pred_taken}, 32'd1);
      check("alias_new_tgt", bus.pred_target, 32'h200);

      holdPc = mPc;
      misBefore = mMis;
      step(1, 0, 1, 1, 32'h90, 1, 32'h300, 0, 32'h94);
      check("halt_hold_pc", bus.imemaddr, holdPc);
      check("halt_miscnt", 32'(bus.mispredict_count), 32'(misBefore + 1));
      gotoPc(32'h90);
      check("halt_trained", bus.pred_target, 32'h300);

      for (int k = 0; k < 400; k++) begin
         rpc = pcs[$urandom % 8];
         rt  = 1'($urandom % 2);
         rtg = pcs[$urandom % 8];
         if ($urandom % 10 < 7) begin
            mPredict(rpc, rpt, rptg);
         end else begin
            rpt  = 1'($urandom % 2);
            rptg = pcs[$urandom % 8];
         end
         step($urandom % 4 != 0, $urandom % 4 == 0, $urandom % 16 == 0,
              $urandom % 2 == 0, rpc, rt, rtg, rpt, rptg);
      end

      @(negedge CLK);
      #1;
      RST = 1'b1;
      mReset();
      #1;
      check("midrst_pc", bus.imemaddr, 32'h0);
      check("midrst_pred", {31'd0, bus.pred_taken}, 32'd0);
      check("midrst_brcnt", 32'(bus.branch_count), 32'd0);
      check("midrst_miscnt", 32'(bus.mispredict_count), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      gotoPc(32'h40);
      check("midrst_btb_inv", {31'd0, bus.pred_taken}, 32'd0);
      fetch(3);

      @(negedge CLK);
      #1;
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Parametrised successor to the datapath's fixed PC-update logic, which always steps to PC+4.
- Owns the fetch PC, a direct-mapped branch target buffer (BTB) with saturating direction counters, mispredict detection and redirect, and branch performance counters.
- Sits in the IF stage: drives imemaddr and the fetch PC/prediction into IF/ID. Takes branch/jump resolution from EX and returns a redirect that the hazard logic uses to flush IF/ID and ID/EX.

Parameters:
- PC_INIT, 0, fetch PC after reset.
- BTB_ENTRIES, 16, BTB depth; power of two, at least 2; IDX_W = log2(BTB_ENTRIES).
- CTR_W, 2, direction counter width, at least 1.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- ihit  in  1  instruction fetch accepted this cycle.
- stall  in  1  hazard stall; hold PC.
- halt  in  1  processor halted; freeze PC.
- imemaddr  out  32  fetch address (equals pc).
- fetch_npc  out  32  pc+4.
- pred_taken  out  1  prediction for the instruction at pc.
- pred_target  out  32  predicted next PC (target if pred_taken, else pc+4).
- res_valid  in  1  EX resolves a control instruction this cycle.
- res_pc  in  32  PC of the resolved instruction.
- res_taken  in  1  actual outcome; jumps report 1.
- res_target  in  32  actual target.
- res_pred_taken  in  1  prediction carried down the pipe.
- res_pred_target  in  32  predicted next PC carried down the pipe.
- redirect  out  1  mispredict; flush younger stages.
- redirect_pc  out  32  corrected PC.
- branch_count  out  CNT_W  resolved control instructions.
- mispredict_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (async, RST=1):
  - pc = PC_INIT.
  - All BTB valid bits = 0.
  - All counters = weakly-not-taken, (1<<(CTR_W-1))-1; for CTR_W=1 this is 0.
  - Both perf counters = 0.
- BTB addressing:
  - idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
  - Each entry holds {valid, tag, target, ctr}.
- Prediction (combinational from pc and current BTB state):
  - hit = valid and tag match.
  - pred_taken = hit and ctr MSB.
  - pred_target = pred_taken ? entry target : pc+4.
- Correct next PC: correct = res_taken ? res_target : res_pc+4.
- Mispredict (combinational):
  - redirect = res_valid and (res_taken != res_pred_taken, or correct != res_pred_target).
  - redirect_pc = correct. Both outputs are 0 when res_valid=0.
- PC update on each rising edge, first match wins:
  1. halt: hold.
  2. redirect: pc <= redirect_pc, regardless of ihit/stall.
  3. ihit and not stall: pc <= pred_target.
  4. Otherwise: hold.
- BTB update on res_valid, indexed by res_pc (independent of halt/stall):
  - Hit, taken: ctr saturating increment; target <= res_target.
  - Hit, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate and overwrite any aliasing entry: valid=1, tag from res_pc, target=res_target, ctr = weakly-taken (1<<(CTR_W-1)).
  - Miss, not taken: no change.
- Update timing: an update becomes visible to prediction the next cycle. A same-cycle read of the entry being updated uses the old state.
- Perf counters, saturating at all-ones:
  - branch_count increments on res_valid.
  - mispredict_count increments on redirect.
- Latency:
  - Prediction is 0-cycle (same cycle as pc).
  - Redirect takes effect on pc at the next edge.

Test Plan:
- Reset, then ihit=1 for 4 cycles with no resolves, BTB_ENTRIES=16 -> after RST: pc=0, pred_taken=0, counters 0; pc steps 0,4,8,C,10.
- stall=1 or ihit=0 for 3 cycles at pc=0x20 -> pc holds at 0x20; resumes to 0x24 when ihit=1, stall=0.
- Resolve res_pc=0x40, res_taken=1, res_target=0x100, res_pred_taken=0, res_pred_target=0x44 -> redirect=1, redirect_pc=0x100, pc=0x100 next edge, mispredict_count=1. Later fetch at 0x40 -> pred_taken=1, pred_target=0x100.
- Counter hysteresis on 0x40, starting at ctr=2'b10: resolve not-taken once -> ctr=01, next fetch of 0x40 predicts not taken; taken three times -> ctr saturates at 11; one not-taken -> still predicts taken.
- Alias: 0x40 is allocated; fetch 0x80 (same idx 0, different tag) -> pred_taken=0. Resolve 0x80 taken to 0x200 -> entry replaced; 0x40 now misses.
- halt=1 together with a redirect to 0x300 -> pc holds; BTB entry and mispredict_count still update. Assert RST mid-run -> pc=PC_INIT immediately, all entries invalid.
